// File: rtl/uart_frac_baud_gen.sv
// uart_frac_baud_gen
// Fractional-N baud tick generator for the UART TX/RX datapaths.
// Produces an oversample tick, an end-of-bit tick and a mid-bit tick.
// Divisor = div_int + div_frac/2^FRAC_W clocks per os_tick.
// The divisor is double-buffered (shadow -> active) so a new setting only
// takes effect on a period boundary, while idle, or on a phase clear.
// OVS must be even and >= 4.
module uart_frac_baud_gen #(
  parameter int DIV_W  = 20,
  parameter int FRAC_W = 4,
  parameter int OVS    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              sync_clr,
  input  logic              cfg_load,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              os_tick,
  output logic              bit_tick,
  output logic              mid_tick,
  output logic              cfg_err
);

  localparam int OSC_W = (OVS > 2) ? $clog2(OVS) : 1;
  localparam logic [OSC_W-1:0] OS_LAST = OSC_W'(OVS - 1);
  localparam logic [OSC_W-1:0] OS_MID  = OSC_W'(OVS / 2 - 1);
  localparam logic [DIV_W-1:0] INT_RST = DIV_W'(2);

  // Shadow and active divisor registers
  logic [DIV_W-1:0]  sh_int;
  logic [FRAC_W-1:0] sh_frac;
  logic [DIV_W-1:0]  act_int;
  logic [FRAC_W-1:0] act_frac;

  // Phase state
  logic [DIV_W:0]    cnt;
  logic [FRAC_W-1:0] acc;
  logic              carry_q;
  logic [OSC_W-1:0]  os_cnt;

  // Combinational helpers
  logic [DIV_W-1:0]  sh_int_nxt;
  logic [FRAC_W-1:0] sh_frac_nxt;
  logic [DIV_W-1:0]  act_int_nxt;
  logic [FRAC_W-1:0] act_frac_nxt;
  logic [DIV_W:0]    p_last;
  logic [FRAC_W:0]   frac_sum;
  logic              wrap;
  logic              act_upd;
  logic              os_is_last;
  logic              os_is_mid;

  // Next-state of the shadow/active divisor and the period-end detection
  always_comb begin
    sh_int_nxt   = cfg_load ? div_int  : sh_int;
    sh_frac_nxt  = cfg_load ? div_frac : sh_frac;
    // P-1 = act_int + carry_q - 1; act_int >= 2 whenever counting, so no underflow
    p_last       = {1'b0, act_int} + {{DIV_W{1'b0}}, carry_q} - {{DIV_W{1'b0}}, 1'b1};
    // >= rather than == so a smaller divisor applied while idle cannot strand cnt
    wrap         = en & ~cfg_err & (cnt >= p_last);
    frac_sum     = {1'b0, acc} + {1'b0, act_frac};
    // Active follows shadow whenever no period is in flight or one just ended
    act_upd      = sync_clr | ~en | cfg_err | wrap;
    act_int_nxt  = act_upd ? sh_int_nxt  : act_int;
    act_frac_nxt = act_upd ? sh_frac_nxt : act_frac;
    os_is_last   = (os_cnt == OS_LAST);
    os_is_mid    = (os_cnt == OS_MID);
  end

  // Divisor double-buffer and configuration error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_int   <= INT_RST;
      sh_frac  <= '0;
      act_int  <= INT_RST;
      act_frac <= '0;
      cfg_err  <= 1'b0;
    end else begin
      sh_int   <= sh_int_nxt;
      sh_frac  <= sh_frac_nxt;
      act_int  <= act_int_nxt;
      act_frac <= act_frac_nxt;
      cfg_err  <= (act_int_nxt < INT_RST);
    end
  end

  // Period counter, fractional accumulator and oversample counter
  always_ff @(posedge clk) begin
    if (rst || sync_clr || cfg_err) begin
      cnt     <= '0;
      acc     <= '0;
      carry_q <= 1'b0;
      os_cnt  <= '0;
    end else if (en) begin
      if (wrap) begin
        cnt            <= '0;
        {carry_q, acc} <= frac_sum;
        os_cnt         <= os_is_last ? '0 : os_cnt + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Registered tick outputs, all aligned with the wrap edge
  always_ff @(posedge clk) begin
    if (rst || sync_clr || cfg_err || !en) begin
      os_tick  <= 1'b0;
      bit_tick <= 1'b0;
      mid_tick <= 1'b0;
    end else begin
      os_tick  <= wrap;
      bit_tick <= wrap & os_is_last;
      mid_tick <= wrap & os_is_mid;
    end
  end

endmodule

// File: tb/tb_uart_frac_baud_gen.sv
// tb_uart_frac_baud_gen
// Directed bench for the fractional baud tick generator (default parameters).
module tb_uart_frac_baud_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        sync_clr;
  logic        cfg_load;
  logic [19:0] div_int;
  logic [3:0]  div_frac;
  logic        os_tick;
  logic        bit_tick;
  logic        mid_tick;
  logic        cfg_err;

  int checks = 0;
  int errors = 0;

  uart_frac_baud_gen #(.DIV_W(20), .FRAC_W(4), .OVS(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .sync_clr (sync_clr),
    .cfg_load (cfg_load),
    .div_int  (div_int),
    .div_frac (div_frac),
    .os_tick  (os_tick),
    .bit_tick (bit_tick),
    .mid_tick (mid_tick),
    .cfg_err  (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    en       = 1'b0;
    sync_clr = 1'b0;
    cfg_load = 1'b0;
    div_int  = '0;
    div_frac = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic load_idle(input int di, input int df);
    en       = 1'b0;
    cfg_load = 1'b1;
    div_int  = 20'(di);
    div_frac = 4'(df);
    step();
    cfg_load = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({os_tick, bit_tick, mid_tick, cfg_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs got=%b want=0000", {os_tick, bit_tick, mid_tick, cfg_err});
    end
    // Reset divisor is {2,0}: first os_tick after two enabled edges
    en = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      checks++;
      if (os_tick !== ((k % 2) == 0)) begin
        errors++;
        $display("FAIL reset_div2 cyc=%0d got=%b want=%b", k, os_tick, ((k % 2) == 0));
      end
    end
  endtask

  task automatic test_basic();
    logic [2:0] exp_t;
    do_reset();
    load_idle(4, 0);
    en = 1'b1;
    for (int k = 1; k <= 140; k++) begin
      step();
      exp_t = {((k % 4) == 0), ((k % 64) == 0), ((k % 64) == 32)};
      checks++;
      if ({os_tick, bit_tick, mid_tick} !== exp_t) begin
        errors++;
        $display("FAIL basic_ticks cyc=%0d got(os,bit,mid)=%b want=%b", k, {os_tick, bit_tick, mid_tick}, exp_t);
      end
    end
  endtask

  task automatic test_frac();
    int next_t;
    int n_exp;
    int n_obs;
    int t_first;
    int t_17;
    do_reset();
    load_idle(4, 8);
    en = 1'b1;
    next_t  = 4;
    n_exp   = 0;
    n_obs   = 0;
    t_first = -1;
    t_17    = -1;
    for (int k = 1; k <= 80; k++) begin
      step();
      checks++;
      if (os_tick !== (k == next_t)) begin
        errors++;
        $display("FAIL frac_os_tick cyc=%0d got=%b want=%b", k, os_tick, (k == next_t));
      end
      if (k == next_t) begin
        n_exp++;
        next_t = next_t + (((n_exp % 2) == 1) ? 4 : 5);
      end
      if (os_tick === 1'b1) begin
        n_obs++;
        if (n_obs == 1)  t_first = k;
        if (n_obs == 17) t_17 = k;
      end
    end
    checks++;
    if ((t_17 - t_first) !== 72) begin
      errors++;
      $display("FAIL frac_span16 got=%0d want=72", t_17 - t_first);
    end
  endtask

  task automatic test_reload();
    do_reset();
    load_idle(4, 0);
    en = 1'b1;
    for (int k = 1; k <= 5; k++) step();
    // cnt is 1 here; new divisor must not disturb the running period
    cfg_load = 1'b1;
    div_int  = 20'd6;
    div_frac = 4'd0;
    step();
    cfg_load = 1'b0;
    checks++;
    if (os_tick !== 1'b0) begin
      errors++;
      $display("FAIL reload_k6 got=%b want=0", os_tick);
    end
    for (int k = 7; k <= 21; k++) begin
      step();
      checks++;
      if (os_tick !== (k == 8 || k == 14 || k == 20)) begin
        errors++;
        $display("FAIL reload_os_tick cyc=%0d got=%b want=%b", k, os_tick, (k == 8 || k == 14 || k == 20));
      end
    end
  endtask

  task automatic test_enable();
    do_reset();
    load_idle(4, 0);
    en = 1'b1;
    for (int k = 1; k <= 6; k++) step();
    en = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      checks++;
      if (os_tick !== 1'b0) begin
        errors++;
        $display("FAIL enable_hold cyc=%0d got=%b want=0", k, os_tick);
      end
    end
    en = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      step();
      checks++;
      if (os_tick !== (j == 2 || j == 6)) begin
        errors++;
        $display("FAIL enable_resume cyc=%0d got=%b want=%b", j, os_tick, (j == 2 || j == 6));
      end
    end
  endtask

  task automatic test_sync_clr();
    logic [2:0] exp_t;
    do_reset();
    load_idle(4, 0);
    en = 1'b1;
    for (int k = 1; k <= 30; k++) step();
    sync_clr = 1'b1;
    step();
    sync_clr = 1'b0;
    checks++;
    if ({os_tick, bit_tick, mid_tick} !== 3'b000) begin
      errors++;
      $display("FAIL sync_clr_edge got=%b want=000", {os_tick, bit_tick, mid_tick});
    end
    for (int j = 1; j <= 70; j++) begin
      step();
      exp_t = {((j % 4) == 0), ((j % 64) == 0), ((j % 64) == 32)};
      checks++;
      if ({os_tick, bit_tick, mid_tick} !== exp_t) begin
        errors++;
        $display("FAIL sync_clr_ticks cyc=%0d got(os,bit,mid)=%b want=%b", j, {os_tick, bit_tick, mid_tick}, exp_t);
      end
    end
  endtask

  task automatic test_sync_load();
    do_reset();
    load_idle(4, 0);
    en = 1'b1;
    for (int k = 1; k <= 6; k++) step();
    sync_clr = 1'b1;
    cfg_load = 1'b1;
    div_int  = 20'd5;
    div_frac = 4'd0;
    step();
    sync_clr = 1'b0;
    cfg_load = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      step();
      checks++;
      if (os_tick !== (j == 5 || j == 10)) begin
        errors++;
        $display("FAIL sync_load cyc=%0d got=%b want=%b", j, os_tick, (j == 5 || j == 10));
      end
    end
  endtask

  task automatic test_cfg_err();
    do_reset();
    load_idle(1, 0);
    checks++;
    if (cfg_err !== 1'b1) begin
      errors++;
      $display("FAIL cfg_err_set got=%b want=1", cfg_err);
    end
    en = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      checks++;
      if ({os_tick, bit_tick, mid_tick, cfg_err} !== 4'b0001) begin
        errors++;
        $display("FAIL cfg_err_quiet cyc=%0d got=%b want=0001", k, {os_tick, bit_tick, mid_tick, cfg_err});
      end
    end
    load_idle(3, 0);
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL cfg_err_clear got=%b want=0", cfg_err);
    end
    en = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      checks++;
      if (os_tick !== ((k % 3) == 0)) begin
        errors++;
        $display("FAIL cfg_err_recover cyc=%0d got=%b want=%b", k, os_tick, ((k % 3) == 0));
      end
    end
  endtask

  task automatic test_rst_mid();
    do_reset();
    load_idle(4, 0);
    en = 1'b1;
    for (int k = 1; k <= 7; k++) step();
    // An os_tick would appear on the next edge without the reset
    rst = 1'b1;
    step();
    checks++;
    if ({os_tick, bit_tick, mid_tick, cfg_err} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_mid_outputs got=%b want=0000", {os_tick, bit_tick, mid_tick, cfg_err});
    end
    rst = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      step();
      checks++;
      if (os_tick !== ((j % 2) == 0)) begin
        errors++;
        $display("FAIL rst_mid_restart cyc=%0d got=%b want=%b", j, os_tick, ((j % 2) == 0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_frac();
    test_reload();
    test_enable();
    test_sync_clr();
    test_sync_load();
    test_cfg_err();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
